led_status_ctrl: RTL
====================

Name: led_status_ctrl

Overview:
Parametrised multi-channel LED driver. Each channel is independently configured to one of four modes: off, steady on, blink, or burst pattern. All lit phases are dimmed by a shared PWM. Sits on the board-control side, driven by the config/UART register block, and feeds the `led_out` pins with status indications (calibration, HDMI lock, DSI link, errors).

Parameters:
N_CH, 4, number of LED channels (1..16)
TICK_DIV, 50000, clk_in cycles per timebase tick (1 kHz at 50 MHz); minimum 2
PWM_BITS, 4, PWM duty resolution in bits
CH_W, $clog2(N_CH) (min 1), derived width of the channel index

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
cfg_wr  in  1  config write strobe, one cycle, sampled on the rising edge
cfg_ch  in  CH_W  target channel of the write
cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
cfg_period  in  8  phase length in ticks
cfg_count  in  4  flashes per burst (BURST mode only)
cfg_duty  in  PWM_BITS  brightness; all-ones = full on
tick_out  in/out: out  1  one-cycle timebase pulse, exported for other blocks
led_out  out  N_CH  registered LED drive, active high

Behaviour:
- Reset is asynchronous, active-low on rst_n_in; clock is clk_in. Reset values:
  - led_out=0, tick_out=0
  - prescaler=0, PWM counter=0
  - every channel: mode OFF, period 1, count 0, duty all-ones, state IDLE, counters 0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick_out=1 for exactly the one cycle in which the count equals TICK_DIV-1.
- PWM:
  - Free-running PWM_BITS counter, incremented every clk_in.
  - pwm_on = (duty == all-ones) OR (pwm_cnt < duty).
  - duty=0 gives fully dark.
- Config writes:
  - On cfg_wr with cfg_ch < N_CH, that channel latches mode/period/count/duty and restarts: phase counter and flash counter cleared, state set to the mode's entry state.
  - cfg_ch >= N_CH: write ignored.
  - period=0 is stored as 1.
  - A write and a tick in the same cycle: the write wins and that tick is not counted for the written channel. Other channels are unaffected.
- Per-channel FSM (states IDLE, LIT, DARK, PAUSE). All counters advance only on tick.
  - OFF: IDLE; output dark.
  - ON: LIT permanently.
  - BLINK: LIT for period ticks, then DARK for period ticks, repeating. Entry state is LIT.
  - BURST: entry LIT. After period ticks go to DARK. After period ticks in DARK, increment flash_cnt; if flash_cnt == count go to PAUSE, else go to LIT. PAUSE lasts 4*period ticks (10-bit phase counter), then clears flash_cnt and goes to LIT.
  - BURST with count=0: entry is PAUSE, output permanently dark, FSM loops in PAUSE.
- Phase change occurs on the tick on which phase_cnt == limit-1; phase_cnt then returns to 0.
- Output:
  - led_out[i] <= (state==LIT) & pwm_on, registered.
  - Latency: write sampled at edge t → channel state updated at t → led_out reflects it at edge t+1.
  - A tick-driven phase change appears on led_out one cycle after the tick.
- Reset mid-pattern returns the channel to OFF immediately (asynchronous); no pattern resumes.

Decomposition:
- Package led_pkg:
  - mode encodings: MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST
  - state encodings: ST_IDLE, ST_LIT, ST_DARK, ST_PAUSE
  - PAUSE_MULT=4
  - widths PERIOD_W=8, COUNT_W=4, PHASE_W=10
- Sub-module led_channel, instantiated N_CH times via generate:
  - holds the config registers, FSM, phase/flash counters, and the output flop.
  - inputs: tick, pwm_on source, write-enable, cfg fields.
- The top holds the prescaler, the PWM counter and the write decode.

Test Plan:
All scenarios use TICK_DIV=4, PWM_BITS=4, N_CH=4.
1. Reset then idle 100 cycles → led_out=0000. tick_out pulses every 4th cycle, first at cycle 4 after reset release.
2. Write ch0 ON with duty=15 → led_out[0]=1 from the cycle after the write, constant. Then write duty=4 → led_out[0] high 4 of every 16 cycles.
3. Write ch1 BLINK, period=2, duty=15 → led_out[1] lit 8 cycles, dark 8 cycles, repeating; first lit cycle is the one after the write.
4. Write ch2 BURST, period=1, count=3 → three 4-cycle lit pulses separated by 4 dark cycles, then 16+4 dark cycles (PAUSE plus last DARK), repeating. BURST with count=0 → never lit.
5. Write with cfg_ch=2 coincident with tick; write with cfg_ch=5 (out of range, widened stimulus) → ch2 restarts with no tick counted; the out-of-range write changes no channel. Write period=0 → behaves as period=1.
6. Assert rst_n_in mid-BURST between clock edges → led_out drops to 0 immediately. After release all channels stay OFF until rewritten.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings and widths for the LED status controller.
// Imported by led_channel and led_status_ctrl.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LIT   = 2'd1,
        ST_DARK  = 2'd2,
        ST_PAUSE = 2'd3
    } led_state_e;

    localparam int PAUSE_MULT = 4;
    localparam int PERIOD_W   = 8;
    localparam int COUNT_W    = 4;
    localparam int PHASE_W    = 10;

    // State a channel enters when (re)configured.
    function automatic led_state_e entry_state(
        input led_mode_e            m,
        input logic [COUNT_W-1:0]   cnt
    );
        led_state_e s;
        s = ST_IDLE;
        unique case (m)
            MODE_OFF:   s = ST_IDLE;
            MODE_ON:    s = ST_LIT;
            MODE_BLINK: s = ST_LIT;
            MODE_BURST: s = (cnt == '0) ? ST_PAUSE : ST_LIT;
            default:    s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, pattern FSM, phase/flash counters
// and output flop. Ports: clk_in, rst_n_in, tick, pwm_cnt, wr_en,
// cfg_mode/period/count/duty (latched on wr_en), led_out.
module led_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wr_en,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [COUNT_W-1:0]  cfg_count,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                led_out
);

    led_mode_e             mode_q, mode_d;
    led_state_e            state_q, state_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [COUNT_W-1:0]    flash_q, flash_d;
    logic [COUNT_W-1:0]    flash_inc;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [PHASE_W-1:0]    per_ext, limit;
    logic                  last, pwm_on, led_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q   <= MODE_OFF;
            state_q  <= ST_IDLE;
            period_q <= PERIOD_W'(1);
            count_q  <= '0;
            flash_q  <= '0;
            duty_q   <= '1;
            phase_q  <= '0;
            led_out  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            state_q  <= state_d;
            period_q <= period_d;
            count_q  <= count_d;
            flash_q  <= flash_d;
            duty_q   <= duty_d;
            phase_q  <= phase_d;
            led_out  <= led_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        state_d   = state_q;
        period_d  = period_q;
        count_d   = count_q;
        flash_d   = flash_q;
        duty_d    = duty_q;
        phase_d   = phase_q;
        per_ext   = PHASE_W'(period_q);
        // PAUSE runs PAUSE_MULT times the normal phase length.
        limit     = (state_q == ST_PAUSE)
                  ? per_ext * PHASE_W'(PAUSE_MULT)
                  : per_ext;
        last      = (phase_q == limit - PHASE_W'(1));
        flash_inc = flash_q + COUNT_W'(1);
        pwm_on    = (&duty_q) || (pwm_cnt < duty_q);
        led_d     = (state_q == ST_LIT) && pwm_on;

        // A write restarts the channel and swallows a coincident tick.
        if (wr_en) begin
            mode_d   = led_mode_e'(cfg_mode);
            period_d = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
            count_d  = cfg_count;
            duty_d   = cfg_duty;
            state_d  = entry_state(led_mode_e'(cfg_mode), cfg_count);
            phase_d  = '0;
            flash_d  = '0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: ;
                ST_LIT: begin
                    if (mode_q != MODE_ON) begin
                        if (last) begin
                            state_d = ST_DARK;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + PHASE_W'(1);
                        end
                    end
                end
                ST_DARK: begin
                    if (last) begin
                        phase_d = '0;
                        state_d = ST_LIT;
                        if (mode_q == MODE_BURST) begin
                            flash_d = flash_inc;
                            if (flash_inc == count_q)
                                state_d = ST_PAUSE;
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (last) begin
                        phase_d = '0;
                        // count==0 keeps the channel parked here.
                        if (count_q != '0) begin
                            flash_d = '0;
                            state_d = ST_LIT;
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED status driver: prescaler tick, shared PWM counter,
// config write decode and N_CH led_channel instances.
// Ports: clk_in, rst_n_in, cfg_wr/cfg_ch/cfg_mode/cfg_period/cfg_count/
// cfg_duty (config write), tick_out (timebase pulse), led_out[N_CH].
module led_status_ctrl
    import led_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 50000,
    parameter int PWM_BITS = 4,
    parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [COUNT_W-1:0]  cfg_count,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                tick_out,
    output logic [N_CH-1:0]     led_out
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]    presc_q;
    logic [PWM_BITS-1:0] pwm_q;

    assign tick_out = (presc_q == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            presc_q <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= tick_out ? '0 : presc_q + PRE_W'(1);
            pwm_q   <= pwm_q + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_en;
        // Indices with no matching channel never assert a write.
        assign wr_en = cfg_wr && (cfg_ch == CH_W'(i));

        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk_in     (clk_in),
            .rst_n_in   (rst_n_in),
            .tick       (tick_out),
            .pwm_cnt    (pwm_q),
            .wr_en      (wr_en),
            .cfg_mode   (cfg_mode),
            .cfg_period (cfg_period),
            .cfg_count  (cfg_count),
            .cfg_duty   (cfg_duty),
            .led_out    (led_out[i])
        );
    end

endmodule
